// File: rtl/rename_pkg.sv
// rename_pkg: shared constants and types for the rename stage.
//   ARCH_REGS  architectural register count (r0 hardwired to preg 0)
//   PHYS_REGS  default physical register count
//   PREG_W     physical tag width
//   preg_t     physical tag type at the default width
//   payload_t  pass-through payload carried alongside a renamed instruction
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int AREG_W    = 5;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = $clog2(PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [31:0]       operand_a;
        logic [31:0]       operand_b;
        logic [31:0]       mem_write_data;
        logic [AREG_W-1:0] read_reg_a;
        logic [AREG_W-1:0] read_reg_b;
        logic [AREG_W-1:0] write_reg;
        logic [4:0]        shift_amount;
        logic [5:0]        alu_control;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } payload_t;
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: physical register free list.
//   clk, reset          clock, synchronous active-high reset
//   stall, flush        flush restores the free bitmap unless stalled
//   alloc               consume alloc_preg this cycle
//   commit              retire: commit_preg becomes committed, commit_old_preg freed
//   alloc_preg          lowest-index free physical register
//   free_count          number of free physical registers
module rename_free_list
    import rename_pkg::*;
#(
    parameter int PHYS_REGS = rename_pkg::PHYS_REGS,
    parameter int PREG_W    = rename_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              alloc,
    input  logic              commit,
    input  logic [PREG_W-1:0] commit_preg,
    input  logic [PREG_W-1:0] commit_old_preg,
    output logic [PREG_W-1:0] alloc_preg,
    output logic [PREG_W:0]   free_count
);

    function automatic logic [PHYS_REGS-1:0] init_free();
        logic [PHYS_REGS-1:0] v;
        v = '0;
        for (int i = ARCH_REGS; i < PHYS_REGS; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [PREG_W:0] popcount(input logic [PHYS_REGS-1:0] v);
        logic [PREG_W:0] n;
        n = '0;
        for (int i = 0; i < PHYS_REGS; i++) n = n + (PREG_W+1)'(v[i]);
        return n;
    endfunction

    localparam logic [PHYS_REGS-1:0] RESET_FREE = init_free();

    logic [PHYS_REGS-1:0] free_bits, free_nxt;
    // pregs referenced by the committed RAT; preg 0 stays set forever
    logic [PHYS_REGS-1:0] cmt_alloc, cmt_alloc_nxt;
    logic                 found;

    always_comb begin
        alloc_preg = '0;
        found      = 1'b0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            if (free_bits[i] && !found) begin
                alloc_preg = PREG_W'(i);
                found      = 1'b1;
            end
        end
    end

    // freed bit is only visible to the encoder from the next cycle on
    always_comb begin
        free_nxt = free_bits;
        if (alloc)  free_nxt[alloc_preg]      = 1'b0;
        if (commit) free_nxt[commit_old_preg] = 1'b1;
    end

    always_comb begin
        cmt_alloc_nxt = cmt_alloc;
        if (commit) begin
            cmt_alloc_nxt[commit_old_preg] = 1'b0;
            cmt_alloc_nxt[commit_preg]     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_bits  <= RESET_FREE;
            cmt_alloc  <= ~RESET_FREE;
            free_count <= (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
        end else begin
            cmt_alloc <= cmt_alloc_nxt;
            if (flush && !stall) begin
                // restore includes a commit landing in the same cycle
                free_bits  <= ~cmt_alloc_nxt;
                free_count <= popcount(~cmt_alloc_nxt);
            end else begin
                free_bits  <= free_nxt;
                free_count <= free_count + (PREG_W+1)'(commit) - (PREG_W+1)'(alloc);
            end
        end
    end

endmodule

// File: rtl/rename_unit.sv
// rename_unit: rename stage between the rename queue and the issue queue.
//   CLK, RESET            clock, synchronous active-high reset
//   STALL, flush          global stall, mispredict flush
//   Instr_Valid_IN, *_IN  queue head and its payload
//   RN_STALL              head not consumed this cycle
//   IQ_Full               issue queue back-pressure
//   Commit_*              retirement of one register write
//   RN_Valid_OUT, PReg*   registered renamed instruction and tags
//   *_OUT                 registered payload copies
//   FreeCount_OUT         free physical register count
module rename_unit
    import rename_pkg::*;
#(
    parameter int PHYS_REGS = rename_pkg::PHYS_REGS,
    parameter int PREG_W    = rename_pkg::PREG_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              flush,
    input  logic              Instr_Valid_IN,
    input  logic [31:0]       Instr1_IN,
    input  logic [31:0]       Instr1_PC_IN,
    input  logic [31:0]       OperandA1_IN,
    input  logic [31:0]       OperandB1_IN,
    input  logic [31:0]       MemWriteData1_IN,
    input  logic [4:0]        ReadRegisterA1_IN,
    input  logic [4:0]        ReadRegisterB1_IN,
    input  logic [4:0]        WriteRegister1_IN,
    input  logic [4:0]        ShiftAmount1_IN,
    input  logic [5:0]        ALU_Control1_IN,
    input  logic              RegWrite1_IN,
    input  logic              MemRead1_IN,
    input  logic              MemWrite1_IN,
    output logic              RN_STALL,
    input  logic              IQ_Full,
    input  logic              Commit_Valid,
    input  logic [4:0]        Commit_ArchReg,
    input  logic [PREG_W-1:0] Commit_PReg,
    input  logic [PREG_W-1:0] Commit_OldPReg,
    output logic              RN_Valid_OUT,
    output logic [PREG_W-1:0] PRegA_OUT,
    output logic [PREG_W-1:0] PRegB_OUT,
    output logic [PREG_W-1:0] PRegDest_OUT,
    output logic [PREG_W-1:0] OldPRegDest_OUT,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [31:0]       OperandA1_OUT,
    output logic [31:0]       OperandB1_OUT,
    output logic [31:0]       MemWriteData1_OUT,
    output logic [4:0]        ReadRegisterA1_OUT,
    output logic [4:0]        ReadRegisterB1_OUT,
    output logic [4:0]        WriteRegister1_OUT,
    output logic [4:0]        ShiftAmount1_OUT,
    output logic [5:0]        ALU_Control1_OUT,
    output logic              RegWrite1_OUT,
    output logic              MemRead1_OUT,
    output logic              MemWrite1_OUT,
    output logic [PREG_W:0]   FreeCount_OUT
);

    logic [PREG_W-1:0] front_rat   [ARCH_REGS];
    logic [PREG_W-1:0] cmt_rat     [ARCH_REGS];
    logic [PREG_W-1:0] cmt_rat_nxt [ARCH_REGS];

    logic              needs_dest, accept, commit_en;
    logic [PREG_W-1:0] alloc_preg;
    logic [PREG_W:0]   free_count;
    payload_t          head, out_q;

    assign head = '{
        instr:          Instr1_IN,
        pc:             Instr1_PC_IN,
        operand_a:      OperandA1_IN,
        operand_b:      OperandB1_IN,
        mem_write_data: MemWriteData1_IN,
        read_reg_a:     ReadRegisterA1_IN,
        read_reg_b:     ReadRegisterB1_IN,
        write_reg:      WriteRegister1_IN,
        shift_amount:   ShiftAmount1_IN,
        alu_control:    ALU_Control1_IN,
        reg_write:      RegWrite1_IN,
        mem_read:       MemRead1_IN,
        mem_write:      MemWrite1_IN
    };

    // writes to r0 never allocate, so r0 stays pinned to preg 0
    assign needs_dest = RegWrite1_IN && (WriteRegister1_IN != 5'd0);
    assign RN_STALL   = IQ_Full || (Instr_Valid_IN && needs_dest && (free_count == '0));
    assign accept     = Instr_Valid_IN && !RN_STALL && !STALL && !flush;
    assign commit_en  = Commit_Valid && (Commit_ArchReg != 5'd0);

    rename_free_list #(.PHYS_REGS(PHYS_REGS), .PREG_W(PREG_W)) u_free_list (
        .clk             (CLK),
        .reset           (RESET),
        .stall           (STALL),
        .flush           (flush),
        .alloc           (accept && needs_dest),
        .commit          (commit_en),
        .commit_preg     (Commit_PReg),
        .commit_old_preg (Commit_OldPReg),
        .alloc_preg      (alloc_preg),
        .free_count      (free_count)
    );

    // flush copies this so a same-cycle commit is not lost
    always_comb begin
        cmt_rat_nxt = cmt_rat;
        if (commit_en) cmt_rat_nxt[Commit_ArchReg] = Commit_PReg;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                front_rat[i] <= PREG_W'(i);
                cmt_rat[i]   <= PREG_W'(i);
            end
            RN_Valid_OUT    <= 1'b0;
            PRegA_OUT       <= '0;
            PRegB_OUT       <= '0;
            PRegDest_OUT    <= '0;
            OldPRegDest_OUT <= '0;
            out_q           <= '0;
        end else begin
            cmt_rat <= cmt_rat_nxt;
            if (!STALL) begin
                if (flush) begin
                    front_rat    <= cmt_rat_nxt;
                    RN_Valid_OUT <= 1'b0;
                end else begin
                    if (accept && needs_dest) front_rat[WriteRegister1_IN] <= alloc_preg;
                    if (!IQ_Full) begin
                        RN_Valid_OUT <= accept;
                        if (accept) begin
                            // sources see the RAT before this instruction's own write
                            PRegA_OUT       <= front_rat[ReadRegisterA1_IN];
                            PRegB_OUT       <= front_rat[ReadRegisterB1_IN];
                            PRegDest_OUT    <= needs_dest ? alloc_preg : '0;
                            OldPRegDest_OUT <= needs_dest ? front_rat[WriteRegister1_IN] : '0;
                            out_q           <= head;
                        end
                    end
                end
            end
        end
    end

    assign Instr1_OUT         = out_q.instr;
    assign Instr1_PC_OUT      = out_q.pc;
    assign OperandA1_OUT      = out_q.operand_a;
    assign OperandB1_OUT      = out_q.operand_b;
    assign MemWriteData1_OUT  = out_q.mem_write_data;
    assign ReadRegisterA1_OUT = out_q.read_reg_a;
    assign ReadRegisterB1_OUT = out_q.read_reg_b;
    assign WriteRegister1_OUT = out_q.write_reg;
    assign ShiftAmount1_OUT   = out_q.shift_amount;
    assign ALU_Control1_OUT   = out_q.alu_control;
    assign RegWrite1_OUT      = out_q.reg_write;
    assign MemRead1_OUT       = out_q.mem_read;
    assign MemWrite1_OUT      = out_q.mem_write;
    assign FreeCount_OUT      = free_count;

endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed stimulus for rename_unit, checked against a
// set/array model of the rename rules plus hand-computed expectations.
module tb_rename_unit;
    localparam int PR = 64;
    localparam int PW = 6;

    logic CLK, RESET, STALL, flush, Instr_Valid_IN;
    logic [31:0] Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN, MemWriteData1_IN;
    logic [4:0]  ReadRegisterA1_IN, ReadRegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, RN_STALL, IQ_Full, Commit_Valid;
    logic [4:0]  Commit_ArchReg;
    logic [PW-1:0] Commit_PReg, Commit_OldPReg;
    logic        RN_Valid_OUT;
    logic [PW-1:0] PRegA_OUT, PRegB_OUT, PRegDest_OUT, OldPRegDest_OUT;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, OperandA1_OUT, OperandB1_OUT, MemWriteData1_OUT;
    logic [4:0]  ReadRegisterA1_OUT, ReadRegisterB1_OUT, WriteRegister1_OUT, ShiftAmount1_OUT;
    logic [5:0]  ALU_Control1_OUT;
    logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT;
    logic [PW:0] FreeCount_OUT;

    rename_unit #(.PHYS_REGS(PR), .PREG_W(PW)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .flush(flush),
        .Instr_Valid_IN(Instr_Valid_IN), .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
        .OperandA1_IN(OperandA1_IN), .OperandB1_IN(OperandB1_IN), .MemWriteData1_IN(MemWriteData1_IN),
        .ReadRegisterA1_IN(ReadRegisterA1_IN), .ReadRegisterB1_IN(ReadRegisterB1_IN),
        .WriteRegister1_IN(WriteRegister1_IN), .ShiftAmount1_IN(ShiftAmount1_IN),
        .ALU_Control1_IN(ALU_Control1_IN), .RegWrite1_IN(RegWrite1_IN), .MemRead1_IN(MemRead1_IN),
        .MemWrite1_IN(MemWrite1_IN), .RN_STALL(RN_STALL), .IQ_Full(IQ_Full),
        .Commit_Valid(Commit_Valid), .Commit_ArchReg(Commit_ArchReg), .Commit_PReg(Commit_PReg),
        .Commit_OldPReg(Commit_OldPReg), .RN_Valid_OUT(RN_Valid_OUT), .PRegA_OUT(PRegA_OUT),
        .PRegB_OUT(PRegB_OUT), .PRegDest_OUT(PRegDest_OUT), .OldPRegDest_OUT(OldPRegDest_OUT),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .OperandA1_OUT(OperandA1_OUT),
        .OperandB1_OUT(OperandB1_OUT), .MemWriteData1_OUT(MemWriteData1_OUT),
        .ReadRegisterA1_OUT(ReadRegisterA1_OUT), .ReadRegisterB1_OUT(ReadRegisterB1_OUT),
        .WriteRegister1_OUT(WriteRegister1_OUT), .ShiftAmount1_OUT(ShiftAmount1_OUT),
        .ALU_Control1_OUT(ALU_Control1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
        .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT), .FreeCount_OUT(FreeCount_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int   m_front [32];
    int   m_cmt   [32];
    bit   m_free  [PR];
    bit   m_ready = 1'b0;
    bit   m_valid;
    int   m_pa, m_pb, m_pd, m_opd;
    logic [188:0] m_pl;

    function automatic int m_count();
        int n = 0;
        for (int p = 0; p < PR; p++) if (m_free[p]) n++;
        return n;
    endfunction

    function automatic int m_lowest();
        for (int p = 0; p < PR; p++) if (m_free[p]) return p;
        return 0;
    endfunction

    function automatic bit m_needs_dest();
        return RegWrite1_IN && WriteRegister1_IN != 0;
    endfunction

    function automatic bit m_stall();
        return IQ_Full || (Instr_Valid_IN && m_needs_dest() && m_count() == 0);
    endfunction

    always @(posedge CLK) begin
        bit acc, nd, used;
        int a_pa, a_pb, a_pd, a_opd;
        if (RESET) begin
            for (int r = 0; r < 32; r++) begin m_front[r] = r; m_cmt[r] = r; end
            for (int p = 0; p < PR; p++) m_free[p] = (p >= 32);
            m_valid = 1'b0; m_pa = 0; m_pb = 0; m_pd = 0; m_opd = 0; m_pl = '0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            nd  = m_needs_dest();
            acc = Instr_Valid_IN && !m_stall() && !STALL && !flush;
            a_pa = 0; a_pb = 0; a_pd = 0; a_opd = 0;
            if (acc) begin
                a_pa = m_front[ReadRegisterA1_IN];
                a_pb = m_front[ReadRegisterB1_IN];
                if (nd) begin
                    a_pd  = m_lowest();
                    a_opd = m_front[WriteRegister1_IN];
                    m_free[a_pd] = 1'b0;
                    m_front[WriteRegister1_IN] = a_pd;
                end
            end
            if (Commit_Valid && Commit_ArchReg != 0) begin
                m_cmt[Commit_ArchReg] = Commit_PReg;
                m_free[Commit_OldPReg] = 1'b1;
            end
            if (!STALL) begin
                if (flush) begin
                    m_front = m_cmt;
                    // free = every preg the committed map does not name
                    for (int p = 0; p < PR; p++) begin
                        used = 1'b0;
                        for (int r = 0; r < 32; r++) if (m_cmt[r] == p) used = 1'b1;
                        m_free[p] = !used;
                    end
                    m_valid = 1'b0;
                end else if (!IQ_Full) begin
                    m_valid = acc;
                    if (acc) begin
                        m_pa = a_pa; m_pb = a_pb; m_pd = a_pd; m_opd = a_opd;
                        m_pl = {Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN, MemWriteData1_IN,
                                ReadRegisterA1_IN, ReadRegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN,
                                ALU_Control1_IN, RegWrite1_IN, MemRead1_IN, MemWrite1_IN};
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (m_ready) begin
            chk("m_rn_stall", RN_STALL, m_stall());
            chk("m_free_count", FreeCount_OUT, m_count());
            chk("m_rn_valid", RN_Valid_OUT, m_valid);
            if (m_valid) begin
                chk("m_preg_a", PRegA_OUT, m_pa);
                chk("m_preg_b", PRegB_OUT, m_pb);
                chk("m_preg_dest", PRegDest_OUT, m_pd);
                chk("m_old_preg_dest", OldPRegDest_OUT, m_opd);
                chk("m_payload", {Instr1_OUT, Instr1_PC_OUT, OperandA1_OUT, OperandB1_OUT, MemWriteData1_OUT,
                                  ReadRegisterA1_OUT, ReadRegisterB1_OUT, WriteRegister1_OUT, ShiftAmount1_OUT,
                                  ALU_Control1_OUT, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT}, m_pl);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] seq = 32'd0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic head(input bit v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] wr, input bit rw);
        seq = seq + 32'd1;
        Instr_Valid_IN    = v;
        ReadRegisterA1_IN = ra;
        ReadRegisterB1_IN = rb;
        WriteRegister1_IN = wr;
        RegWrite1_IN      = rw;
        Instr1_IN         = 32'h0a00_0000 + seq;
        Instr1_PC_IN      = seq << 2;
        OperandA1_IN      = seq * 32'd3;
        OperandB1_IN      = ~seq;
        MemWriteData1_IN  = seq ^ 32'h5a5a_5a5a;
        ShiftAmount1_IN   = seq[4:0];
        ALU_Control1_IN   = seq[5:0];
        MemRead1_IN       = seq[0];
        MemWrite1_IN      = seq[1];
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; flush = 1'b0; IQ_Full = 1'b0;
        Commit_Valid = 1'b0; Commit_ArchReg = '0; Commit_PReg = '0; Commit_OldPReg = '0;
        head(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) tick();
        RESET = 1'b0;
        chk("reset_free_count", FreeCount_OUT, 32);
        chk("reset_rn_stall", RN_STALL, 0);
        chk("reset_rn_valid", RN_Valid_OUT, 0);
        chk("reset_preg_dest", PRegDest_OUT, 0);

        // add r3,r1,r2 ; add r3,r3,r3
        head(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        chk("add1_valid", RN_Valid_OUT, 1);
        chk("add1_pa", PRegA_OUT, 1);
        chk("add1_pb", PRegB_OUT, 2);
        chk("add1_pd", PRegDest_OUT, 32);
        chk("add1_opd", OldPRegDest_OUT, 3);
        head(1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
        tick();
        chk("add2_pa", PRegA_OUT, 32);
        chk("add2_pb", PRegB_OUT, 32);
        chk("add2_pd", PRegDest_OUT, 33);
        chk("add2_opd", OldPRegDest_OUT, 32);
        chk("add2_free", FreeCount_OUT, 30);
        head(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // flush with nothing committed
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", RN_Valid_OUT, 0);
        chk("flush_free", FreeCount_OUT, 32);
        head(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        tick();
        chk("flush_r3_pa", PRegA_OUT, 3);
        chk("nowr_pd", PRegDest_OUT, 0);
        chk("nowr_opd", OldPRegDest_OUT, 0);
        head(1'b1, 5'd0, 5'd5, 5'd0, 1'b1);
        tick();
        chk("r0wr_pd", PRegDest_OUT, 0);
        chk("r0wr_pb", PRegB_OUT, 5);
        chk("r0wr_free", FreeCount_OUT, 32);

        // issue queue full for 3 cycles
        IQ_Full = 1'b1;
        head(1'b1, 5'd4, 5'd5, 5'd6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("iqf_stall", RN_STALL, 1);
            tick();
            chk("iqf_hold_valid", RN_Valid_OUT, 1);
            chk("iqf_hold_pb", PRegB_OUT, 5);
            chk("iqf_hold_pd", PRegDest_OUT, 0);
            chk("iqf_free", FreeCount_OUT, 32);
        end
        IQ_Full = 1'b0;
        tick();
        chk("iqf_release_pa", PRegA_OUT, 4);
        chk("iqf_release_pd", PRegDest_OUT, 32);
        chk("iqf_release_opd", OldPRegDest_OUT, 6);
        chk("iqf_release_free", FreeCount_OUT, 31);

        // global stall holds everything
        STALL = 1'b1;
        head(1'b1, 5'd6, 5'd6, 5'd7, 1'b1);
        tick();
        chk("stall_hold_pd", PRegDest_OUT, 32);
        chk("stall_hold_free", FreeCount_OUT, 31);
        STALL = 1'b0;
        tick();
        chk("unstall_pa", PRegA_OUT, 32);
        chk("unstall_pd", PRegDest_OUT, 33);
        chk("unstall_opd", OldPRegDest_OUT, 7);
        head(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // exhaust the free list
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("exh_start_free", FreeCount_OUT, 32);
        for (int i = 0; i < 32; i++) begin
            head(1'b1, 5'd1, 5'd2, 5'(((i + 2) % 31) + 1), 1'b1);
            tick();
        end
        chk("exh_free_zero", FreeCount_OUT, 0);
        head(1'b1, 5'd1, 5'd2, 5'd4, 1'b1);
        #1;
        chk("exh_33rd_stall", RN_STALL, 1);
        Commit_Valid = 1'b1; Commit_ArchReg = 5'd3; Commit_PReg = 6'd32; Commit_OldPReg = 6'd3;
        #1;
        chk("exh_commit_same_cycle_stall", RN_STALL, 1);
        tick();
        Commit_Valid = 1'b0;
        #1;
        chk("exh_after_commit_free", FreeCount_OUT, 1);
        chk("exh_after_commit_stall", RN_STALL, 0);
        tick();
        chk("exh_33rd_valid", RN_Valid_OUT, 1);
        chk("exh_33rd_pd", PRegDest_OUT, 3);
        head(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // flush together with a commit of r4
        Commit_Valid = 1'b1; Commit_ArchReg = 5'd4;
        Commit_PReg = 6'(m_front[4]); Commit_OldPReg = 6'(m_cmt[4]);
        flush = 1'b1;
        tick();
        Commit_Valid = 1'b0; flush = 1'b0;
        chk("flush_commit_free", FreeCount_OUT, 32);
        head(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
        tick();
        chk("flush_commit_r3", PRegA_OUT, 32);
        head(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
